// File: rtl/config_pkg.sv
// Shared fixed-point configuration for the multiply pipeline: formats, rounding
// bias and the clamp helper used by the requantiser.
package config_pkg;

  localparam int FixedPointPrecision = 16;
  localparam int FixedPointExponent  = -8;

  // Product width plus any left-shift headroom plus one guard bit so the
  // rounding add can never overflow.
  localparam int FixedPointGuardWidth =
    2 * FixedPointPrecision + ((FixedPointExponent > 0) ? FixedPointExponent : 0) + 1;

  localparam int FixedPointRoundBias =
    (FixedPointExponent < 0) ? (1 << (-FixedPointExponent - 1)) : 0;

  typedef logic signed [2*FixedPointPrecision-1:0] fixed_point_product_t;
  typedef logic signed [FixedPointGuardWidth-1:0]  fixed_point_wide_t;

  typedef struct packed {
    logic [FixedPointPrecision-1:0] value;
    logic                           sat;
  } fixed_point_sat_t;

  function automatic fixed_point_sat_t fixed_point_saturate(input fixed_point_wide_t v);
    fixed_point_wide_t hi;
    fixed_point_wide_t lo;
    fixed_point_sat_t  r;
    hi = fixed_point_wide_t'((1 << (FixedPointPrecision - 1)) - 1);
    lo = ~hi;
    if (v > hi) begin
      r.value = hi[FixedPointPrecision-1:0];
      r.sat   = 1'b1;
    end else if (v < lo) begin
      r.value = lo[FixedPointPrecision-1:0];
      r.sat   = 1'b1;
    end else begin
      r.value = v[FixedPointPrecision-1:0];
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fixed_point_requant.sv
// One lane of requantisation: binary-point shift with optional round-half-up,
// then clamp to the result width with a saturation flag.
module fixed_point_requant
  import config_pkg::*;
#(
  parameter int Width    = FixedPointPrecision,
  parameter int Exponent = FixedPointExponent
) (
  input  logic signed [2*Width-1:0] prod_i,
  input  logic                      round_i,
  output logic        [Width-1:0]   y_o,
  output logic                      sat_o
);

  localparam int PosExp = (Exponent > 0) ? Exponent : 0;
  localparam int WideW  = 2 * Width + PosExp + 1;

  logic signed [WideW-1:0] ext;
  logic signed [WideW-1:0] scaled;

  assign ext = {{(PosExp + 1){prod_i[2*Width-1]}}, prod_i};

  if (Exponent < 0) begin : g_right
    localparam int Shift = -Exponent;
    logic signed [WideW-1:0] bias;
    assign bias   = round_i ? WideW'(WideW'(1) << (Shift - 1)) : '0;
    assign scaled = (ext + bias) >>> Shift;
  end else begin : g_left
    logic unused_round;
    assign unused_round = round_i;
    assign scaled       = ext <<< Exponent;
  end

  if (Width == FixedPointPrecision && Exponent == FixedPointExponent) begin : g_pkg_sat
    fixed_point_sat_t res;
    assign res   = fixed_point_saturate(scaled);
    assign y_o   = res.value;
    assign sat_o = res.sat;
  end else begin : g_gen_sat
    logic signed [WideW-1:0] hi;
    logic signed [WideW-1:0] lo;
    always_comb begin
      hi    = (WideW'(1) << (Width - 1)) - WideW'(1);
      lo    = ~hi;
      y_o   = scaled[Width-1:0];
      sat_o = 1'b0;
      if (scaled > hi) begin
        y_o   = hi[Width-1:0];
        sat_o = 1'b1;
      end else if (scaled < lo) begin
        y_o   = lo[Width-1:0];
        sat_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vector_mul_pipe.sv
// Two-stage multi-lane fixed-point multiplier (multiply, then requantise) with
// valid/ready on both sides and a saturating count of clamped output beats.
module vector_mul_pipe
  import config_pkg::*;
#(
  parameter int Lanes      = 4,
  parameter int Width      = FixedPointPrecision,
  parameter int Exponent   = FixedPointExponent,
  parameter int CountWidth = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [Lanes*Width-1:0]   a_i,
  input  logic [Lanes*Width-1:0]   b_i,
  input  logic                     round_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  output logic [Lanes*Width-1:0]   y_o,
  output logic [Lanes-1:0]         sat_o,
  output logic                     y_valid_o,
  input  logic                     y_ready_i,
  input  logic                     clear_count_i,
  output logic [CountWidth-1:0]    sat_count_o
);

  localparam int ProdW = 2 * Width;

  // Handshake: a beat moves across a boundary only on a cycle where the
  // sender's valid and the receiver's ready are both high; once y_valid_o is
  // raised, y_o/sat_o/y_valid_o stay frozen until y_ready_i is seen.
  logic                     s1_valid_q, s1_valid_d;
  logic                     s1_round_q, s1_round_d;
  logic [Lanes*ProdW-1:0]   s1_prod_q, s1_prod_d;
  logic                     s2_valid_q, s2_valid_d;
  logic [Lanes*Width-1:0]   y_q, y_d, req_y;
  logic [Lanes-1:0]         sat_q, sat_d, req_sat;
  logic [CountWidth-1:0]    cnt_q, cnt_d;
  logic                     out_xfer, s2_load, s1_load;

  assign out_xfer   = s2_valid_q & y_ready_i;
  assign s2_load    = s1_valid_q & (~s2_valid_q | out_xfer);
  assign in_ready_o = ~s1_valid_q | s2_load;
  assign s1_load    = in_valid_i & in_ready_o;

  for (genvar k = 0; k < Lanes; k++) begin : g_lane
    fixed_point_requant #(
      .Width    (Width),
      .Exponent (Exponent)
    ) u_requant (
      .prod_i  (s1_prod_q[k*ProdW +: ProdW]),
      .round_i (s1_round_q),
      .y_o     (req_y[k*Width +: Width]),
      .sat_o   (req_sat[k])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_round_d = s1_round_q;
    s1_prod_d  = s1_prod_q;
    if (s1_load) begin
      s1_valid_d = 1'b1;
      s1_round_d = round_i;
      for (int k = 0; k < Lanes; k++) begin
        s1_prod_d[k*ProdW +: ProdW] =
          $signed({{Width{a_i[k*Width+Width-1]}}, a_i[k*Width +: Width]}) *
          $signed({{Width{b_i[k*Width+Width-1]}}, b_i[k*Width +: Width]});
      end
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    y_d        = y_q;
    sat_d      = sat_q;
    if (s2_load) begin
      s2_valid_d = 1'b1;
      y_d        = req_y;
      sat_d      = req_sat;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end
  end

  // Clear wins over a same-cycle counted transfer; the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_count_i) begin
      cnt_d = '0;
    end else if (out_xfer && (|sat_q) && !(&cnt_q)) begin
      cnt_d = cnt_q + CountWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_round_q <= 1'b0;
      s1_prod_q  <= '0;
      s2_valid_q <= 1'b0;
      y_q        <= '0;
      sat_q      <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_round_q <= s1_round_d;
      s1_prod_q  <= s1_prod_d;
      s2_valid_q <= s2_valid_d;
      y_q        <= y_d;
      sat_q      <= sat_d;
      cnt_q      <= cnt_d;
    end
  end

  assign y_o         = y_q;
  assign sat_o       = sat_q;
  assign y_valid_o   = s2_valid_q;
  assign sat_count_o = cnt_q;

endmodule

// File: tb/tb_vector_mul_pipe.sv
// Bench for vector_mul_pipe: fixed vectors, latency/stall/reset sequences and
// randomized traffic against an arithmetic reference model.
module tb_vector_mul_pipe;

  localparam int LW = 64;

  logic          clk, rst, round_i, in_valid_i, y_ready_i, clear_count_i;
  logic [LW-1:0] a_i, b_i, y_o, s_y_o;
  logic          in_ready_o, y_valid_o, s_in_ready_o, s_y_valid_o;
  logic [3:0]    sat_o, s_sat_o;
  logic [31:0]   sat_count_o;
  logic [2:0]    s_sat_count_o;

  int            checks, errors, out_count;
  logic [67:0]   exp_q[$];
  logic [31:0]   exp_cnt;
  logic [2:0]    exp_cnt_s;
  bit            saw_in_stall, rand_done;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        rnd;
    logic [63:0] y;
    logic [3:0]  sat;
  } vec_t;
  vec_t tbl[6];

  vector_mul_pipe #(.Lanes(4), .Width(16), .Exponent(-8), .CountWidth(32)) u_dut (
    .clk_i(clk), .rst_i(rst), .a_i(a_i), .b_i(b_i), .round_i(round_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .y_o(y_o), .sat_o(sat_o),
    .y_valid_o(y_valid_o), .y_ready_i(y_ready_i), .clear_count_i(clear_count_i),
    .sat_count_o(sat_count_o)
  );

  vector_mul_pipe #(.Lanes(4), .Width(16), .Exponent(-8), .CountWidth(3)) u_dut_small (
    .clk_i(clk), .rst_i(rst), .a_i(a_i), .b_i(b_i), .round_i(round_i),
    .in_valid_i(in_valid_i), .in_ready_o(s_in_ready_o), .y_o(s_y_o), .sat_o(s_sat_o),
    .y_valid_o(s_y_valid_o), .y_ready_i(y_ready_i), .clear_count_i(clear_count_i),
    .sat_count_o(s_sat_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact product, optional +0.5 LSB, floor-divide by 2^8, clamp.
  function automatic logic [67:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic rnd);
    logic [63:0] y;
    logic [3:0]  s;
    longint      p, q;
    for (int k = 0; k < 4; k++) begin
      p = longint'($signed(a[k*16 +: 16])) * longint'($signed(b[k*16 +: 16]));
      if (rnd) p = p + 128;
      q = p / 256;
      if (p < 0 && (p % 256) != 0) q = q - 1;
      s[k] = 1'b0;
      if (q > 32767) begin
        q = 32767;
        s[k] = 1'b1;
      end else if (q < -32768) begin
        q = -32768;
        s[k] = 1'b1;
      end
      y[k*16 +: 16] = q[15:0];
    end
    return {y, s};
  endfunction

  function automatic logic [15:0] rnd_op();
    logic [15:0] r;
    case ($urandom_range(0, 3))
      0: r = 16'($urandom_range(0, 1023)) - 16'd512;
      1: case ($urandom_range(0, 3))
           0: r = 16'h8000;
           1: r = 16'h7FFF;
           2: r = 16'hFFFF;
           default: r = 16'h0001;
         endcase
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [63:0] a, input logic [63:0] b, input logic rnd);
    int waited;
    bit ok;
    a_i = a;
    b_i = b;
    round_i = rnd;
    in_valid_i = 1'b1;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 60) begin
      @(negedge clk);
      if (in_ready_o) ok = 1'b1;
      else waited++;
    end
    if (ok) exp_q.push_back(model(a, b, rnd));
    else check("send_timeout", 72'd0, 72'd1);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check(name, 72'(exp_q.size()), 72'd0);
  endtask

  task automatic lat_check(input int idx);
    send_beat(tbl[idx].a, tbl[idx].b, tbl[idx].rnd);
    @(negedge clk);
    check("lat_cycle1", 72'(y_valid_o), 72'd0);
    @(negedge clk);
    check("lat_cycle2", {3'd0, y_valid_o, y_o, sat_o}, {3'd0, 1'b1, tbl[idx].y, tbl[idx].sat});
    @(negedge clk);
    check("lat_pulse", 72'(y_valid_o), 72'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    logic        prev_stall;
    logic [63:0] prev_y;
    logic [3:0]  prev_sat, esat;
    logic [67:0] e;
    bit          xfer;
    prev_stall = 1'b0;
    prev_y = '0;
    prev_sat = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        exp_cnt = '0;
        exp_cnt_s = '0;
        prev_stall = 1'b0;
      end else begin
        check("sat_count", 72'(sat_count_o), 72'(exp_cnt));
        check("sat_count_small", 72'(s_sat_count_o), 72'(exp_cnt_s));
        if (prev_stall)
          check("hold_stable", {3'd0, y_valid_o, y_o, sat_o}, {3'd0, 1'b1, prev_y, prev_sat});
        if (y_ready_i) check("in_ready_free", 72'({in_ready_o, s_in_ready_o}), 72'd3);
        if (in_valid_i && !in_ready_o) saw_in_stall = 1'b1;
        xfer = y_valid_o && y_ready_i;
        esat = '0;
        if (xfer) begin
          out_count++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", {3'd0, y_valid_o, y_o, sat_o}, 72'd0);
            esat = sat_o;
          end else begin
            e = exp_q.pop_front();
            check("beat_data", 72'({y_o, sat_o}), 72'(e));
            check("beat_data_small", 72'({s_y_o, s_sat_o, s_y_valid_o}), 72'({e, 1'b1}));
            esat = e[3:0];
          end
        end
        if (clear_count_i) begin
          exp_cnt = '0;
          exp_cnt_s = '0;
        end else if (xfer && (esat != 4'd0)) begin
          if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
          if (exp_cnt_s != 3'd7) exp_cnt_s = exp_cnt_s + 1;
        end
        prev_stall = y_valid_o && !y_ready_i;
        prev_y = y_o;
        prev_sat = sat_o;
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    out_count = 0;
    exp_cnt = '0;
    exp_cnt_s = '0;
    saw_in_stall = 1'b0;
    rand_done = 1'b0;
    rst = 1'b1;
    a_i = '0;
    b_i = '0;
    round_i = 1'b0;
    in_valid_i = 1'b0;
    y_ready_i = 1'b1;
    clear_count_i = 1'b0;

    tbl[0] = '{a: {4{16'h0180}}, b: {4{16'h0200}}, rnd: 1'b0,
               y: {4{16'h0300}}, sat: 4'b0000};
    tbl[1] = '{a: {16'h0001, 16'h0180, 16'h8000, 16'h7F00},
               b: {16'h0080, 16'h0200, 16'h0200, 16'h0200}, rnd: 1'b0,
               y: {16'h0000, 16'h0300, 16'h8000, 16'h7FFF}, sat: 4'b0011};
    tbl[2] = '{a: {16'h0000, 16'h8000, 16'hFFFF, 16'h0001},
               b: {16'h1234, 16'h8000, 16'h0080, 16'h0080}, rnd: 1'b0,
               y: {16'h0000, 16'h7FFF, 16'hFFFF, 16'h0000}, sat: 4'b0100};
    tbl[3] = '{a: {16'h0000, 16'h8000, 16'hFFFF, 16'h0001},
               b: {16'h1234, 16'h8000, 16'h0080, 16'h0080}, rnd: 1'b1,
               y: {16'h0000, 16'h7FFF, 16'h0000, 16'h0001}, sat: 4'b0100};
    tbl[4] = '{a: {16'h7FFF, 16'hFF00, 16'h0100, 16'hFFFF},
               b: {16'h0100, 16'h0100, 16'h0100, 16'h0180}, rnd: 1'b1,
               y: {16'h7FFF, 16'hFF00, 16'h0100, 16'hFFFF}, sat: 4'b0000};
    tbl[5] = '{a: {16'hFFFF, 16'h7FFF, 16'h8000, 16'h8000},
               b: {16'hFFFF, 16'h7FFF, 16'h0100, 16'hFF00}, rnd: 1'b1,
               y: {16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF}, sat: 4'b0101};

    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_y", 72'(y_o), 72'd0);
    check("rst_sat", 72'(sat_o), 72'd0);
    check("rst_valid", 72'(y_valid_o), 72'd0);
    check("rst_count", 72'(sat_count_o), 72'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", 72'(in_ready_o), 72'd1);

    // Basic beat with exact latency and a one-cycle valid pulse
    lat_check(0);

    // Fixed vectors
    for (int i = 0; i < 6; i++) begin
      bit got;
      send_beat(tbl[i].a, tbl[i].b, tbl[i].rnd);
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        @(negedge clk);
        if (y_valid_o) got = 1'b1;
      end
      check("tbl_valid", 72'(got), 72'd1);
      if (got) check("tbl_y", 72'({y_o, sat_o}), 72'({tbl[i].y, tbl[i].sat}));
      @(posedge clk);
      #1;
    end
    drain("drain_tbl");
    check("cnt_after_tbl", 72'(sat_count_o), 72'd4);

    // Counter counts beats, and the narrow counter sticks at its maximum
    for (int i = 0; i < 10; i++) send_beat({4{16'h7F00}}, {4{16'h0200}}, 1'b0);
    drain("drain_satcnt");
    check("cnt_per_beat", 72'(sat_count_o), 72'd14);
    check("cnt_small_max", 72'(s_sat_count_o), 72'd7);

    // Clear coinciding with a saturating output transfer
    y_ready_i = 1'b0;
    send_beat({4{16'h8000}}, {4{16'h0200}}, 1'b0);
    for (int w = 0; w < 10 && !y_valid_o; w++) begin
      @(posedge clk);
      #1;
    end
    check("clr_pending_valid", 72'(y_valid_o), 72'd1);
    clear_count_i = 1'b1;
    y_ready_i = 1'b1;
    @(posedge clk);
    #1;
    clear_count_i = 1'b0;
    check("clr_count", 72'(sat_count_o), 72'd0);
    check("clr_count_small", 72'(s_sat_count_o), 72'd0);
    check("clr_beat_taken", 72'(y_valid_o), 72'd0);

    // Backpressure: 8 back-to-back beats, output stalled for 5 cycles
    begin
      int base;
      base = out_count;
      saw_in_stall = 1'b0;
      fork
        begin
          for (int i = 0; i < 8; i++)
            send_beat({rnd_op(), rnd_op(), rnd_op(), rnd_op()},
                      {rnd_op(), rnd_op(), rnd_op(), rnd_op()}, 1'($urandom_range(0, 1)));
        end
        begin
          repeat (3) @(posedge clk);
          #1 y_ready_i = 1'b0;
          repeat (5) @(posedge clk);
          #1 y_ready_i = 1'b1;
        end
      join
      drain("drain_bp");
      check("bp_beat_count", 72'(out_count - base), 72'd8);
      check("bp_in_ready_fell", 72'(saw_in_stall), 72'd1);
    end

    // Randomized traffic with random stalls and occasional clears
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2) == 0 ? 1 : 0) begin
            @(posedge clk);
            #1;
          end
          send_beat({rnd_op(), rnd_op(), rnd_op(), rnd_op()},
                    {rnd_op(), rnd_op(), rnd_op(), rnd_op()}, 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          y_ready_i = ($urandom_range(0, 3) != 0);
          clear_count_i = ($urandom_range(0, 40) == 0);
        end
      end
    join
    y_ready_i = 1'b1;
    clear_count_i = 1'b0;
    drain("drain_rand");

    // Asynchronous reset with two beats in flight
    y_ready_i = 1'b0;
    send_beat(tbl[1].a, tbl[1].b, 1'b0);
    send_beat(tbl[2].a, tbl[2].b, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 72'(y_valid_o), 72'd0);
    check("midrst_y", 72'(y_o), 72'd0);
    check("midrst_sat", 72'(sat_o), 72'd0);
    check("midrst_count", 72'(sat_count_o), 72'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    y_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_no_beat", 72'(y_valid_o), 72'd0);
    end
    @(posedge clk);
    #1;
    lat_check(1);
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
